apb_led_sw_ctrl: RTL and testbench

- APB3 slave peripheral for the SoC's user APB slave port.
- Drives NUM_LED LEDs with per-channel on/off and PWM brightness.
- Samples NUM_SW switches through a synchroniser and a programmable debouncer, and raises a maskable change interrupt.
- Supersedes the direct GPIO-to-LED and switch wiring at top level.

---
 rtl/apb_led_sw_pkg.sv | 34 +++
 rtl/apb_led_sw_ctrl_sw_debounce.sv | 49 ++++
 rtl/apb_led_sw_ctrl.sv | 170 +++++++++++++++++
 tb/tb_apb_led_sw_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_led_sw_pkg.sv
// Shared register map, decode width and identification constants for the
// APB LED/switch controller.
package apb_led_sw_pkg;

  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] OFS_LED_EN    = 16'h0000;
  localparam logic [ADDR_W-1:0] OFS_PRESC     = 16'h0004;
  localparam logic [ADDR_W-1:0] OFS_SW_STATE  = 16'h0008;
  localparam logic [ADDR_W-1:0] OFS_IRQ_EN    = 16'h000C;
  localparam logic [ADDR_W-1:0] OFS_PEND      = 16'h0010;
  localparam logic [ADDR_W-1:0] OFS_DB_TH     = 16'h0014;
  localparam logic [ADDR_W-1:0] OFS_INFO      = 16'h0018;
  localparam logic [ADDR_W-1:0] OFS_DUTY_BASE = 16'h0040;

  localparam logic [7:0] INFO_VERSION = 8'h01;

  typedef enum logic [3:0] {
    REG_NONE,
    REG_LED_EN,
    REG_PRESC,
    REG_SW_STATE,
    REG_IRQ_EN,
    REG_PEND,
    REG_DB_TH,
    REG_INFO,
    REG_DUTY
  } reg_sel_e;

  function automatic logic [31:0] info_word(input int nsw, input int nled, input int pwmb);
    return {INFO_VERSION, 8'(nsw), 8'(nled), 8'(pwmb)};
  endfunction

endpackage

// File: rtl/apb_led_sw_ctrl_sw_debounce.sv
// One switch channel: two-flop synchroniser followed by a threshold debouncer
// that emits a single-cycle pulse whenever the debounced value flips.
module sw_debounce #(
  parameter int DB_BITS = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sw_i,
  input  logic [DB_BITS-1:0] db_th_i,
  output logic               stable_o,
  output logic               change_o
);

  logic               sync1_q, sync2_q;
  logic               stable_q, stable_d;
  logic [DB_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    change_o = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= db_th_i) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      change_o = 1'b1;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + DB_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/apb_led_sw_ctrl.sv
// APB3 peripheral driving PWM-dimmed LEDs and sampling debounced switches
// with a maskable change interrupt. Zero wait states, combinational read mux.
module apb_led_sw_ctrl
  import apb_led_sw_pkg::*;
#(
  parameter int NUM_LED  = 8,
  parameter int NUM_SW   = 4,
  parameter int PWM_BITS = 8,
  parameter int DB_BITS  = 16
) (
  input  logic                io_systemClk,
  input  logic                io_systemReset,
  input  logic [ADDR_W-1:0]   io_apbSlave_PADDR,
  input  logic                io_apbSlave_PSEL,
  input  logic                io_apbSlave_PENABLE,
  input  logic                io_apbSlave_PWRITE,
  input  logic [31:0]         io_apbSlave_PWDATA,
  output logic [31:0]         io_apbSlave_PRDATA,
  output logic                io_apbSlave_PREADY,
  output logic                io_apbSlave_PSLVERROR,
  output logic [NUM_LED-1:0]  o_led,
  input  logic [NUM_SW-1:0]   i_sw,
  output logic                o_irq
);

  reg_sel_e            sel;
  logic [3:0]          duty_idx;
  logic                apb_wr;

  logic [NUM_LED-1:0]  led_en_q, led_en_d;
  logic [15:0]         presc_q, presc_d;
  logic [NUM_SW-1:0]   irq_en_q, irq_en_d;
  logic [NUM_SW-1:0]   pend_q, pend_d;
  logic [DB_BITS-1:0]  db_th_q, db_th_d;
  logic [PWM_BITS-1:0] duty_q [NUM_LED];
  logic [PWM_BITS-1:0] duty_d [NUM_LED];

  logic [15:0]         pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick;
  logic [NUM_LED-1:0]  led_q, led_d;
  logic                irq_q, irq_d;

  logic [NUM_SW-1:0]   sw_stable, sw_change;
  logic                unused_pwdata;

  assign duty_idx = io_apbSlave_PADDR[5:2];

  // DUTY window is 0x40..0x7C; slots beyond NUM_LED stay unmapped.
  always_comb begin
    sel = REG_NONE;
    case (io_apbSlave_PADDR)
      OFS_LED_EN:   sel = REG_LED_EN;
      OFS_PRESC:    sel = REG_PRESC;
      OFS_SW_STATE: sel = REG_SW_STATE;
      OFS_IRQ_EN:   sel = REG_IRQ_EN;
      OFS_PEND:     sel = REG_PEND;
      OFS_DB_TH:    sel = REG_DB_TH;
      OFS_INFO:     sel = REG_INFO;
      default: begin
        if (io_apbSlave_PADDR[ADDR_W-1:6] == OFS_DUTY_BASE[ADDR_W-1:6] &&
            io_apbSlave_PADDR[1:0] == 2'b00 && int'(duty_idx) < NUM_LED)
          sel = REG_DUTY;
      end
    endcase
  end

  assign apb_wr                = io_apbSlave_PSEL & io_apbSlave_PENABLE & io_apbSlave_PWRITE;
  assign io_apbSlave_PREADY    = 1'b1;
  assign io_apbSlave_PSLVERROR = io_apbSlave_PSEL & io_apbSlave_PENABLE & (sel == REG_NONE);
  assign unused_pwdata         = ^io_apbSlave_PWDATA;

  always_comb begin
    io_apbSlave_PRDATA = '0;
    if (io_apbSlave_PSEL) begin
      case (sel)
        REG_LED_EN:   io_apbSlave_PRDATA[NUM_LED-1:0] = led_en_q;
        REG_PRESC:    io_apbSlave_PRDATA[15:0]        = presc_q;
        REG_SW_STATE: io_apbSlave_PRDATA[NUM_SW-1:0]  = sw_stable;
        REG_IRQ_EN:   io_apbSlave_PRDATA[NUM_SW-1:0]  = irq_en_q;
        REG_PEND:     io_apbSlave_PRDATA[NUM_SW-1:0]  = pend_q;
        REG_DB_TH:    io_apbSlave_PRDATA[DB_BITS-1:0] = db_th_q;
        REG_INFO:     io_apbSlave_PRDATA = info_word(NUM_SW, NUM_LED, PWM_BITS);
        REG_DUTY: begin
          for (int n = 0; n < NUM_LED; n++)
            if (duty_idx == 4'(n)) io_apbSlave_PRDATA[PWM_BITS-1:0] = duty_q[n];
        end
        default: ;
      endcase
    end
  end

  // A new debounced change is OR-ed in after the W1C so set wins a collision.
  always_comb begin
    led_en_d = led_en_q;
    presc_d  = presc_q;
    irq_en_d = irq_en_q;
    pend_d   = pend_q;
    db_th_d  = db_th_q;
    duty_d   = duty_q;
    if (apb_wr) begin
      case (sel)
        REG_LED_EN: led_en_d = io_apbSlave_PWDATA[NUM_LED-1:0];
        REG_PRESC:  presc_d  = io_apbSlave_PWDATA[15:0];
        REG_IRQ_EN: irq_en_d = io_apbSlave_PWDATA[NUM_SW-1:0];
        REG_PEND:   pend_d   = pend_q & ~io_apbSlave_PWDATA[NUM_SW-1:0];
        REG_DB_TH:  db_th_d  = io_apbSlave_PWDATA[DB_BITS-1:0];
        REG_DUTY: begin
          for (int n = 0; n < NUM_LED; n++)
            if (duty_idx == 4'(n)) duty_d[n] = io_apbSlave_PWDATA[PWM_BITS-1:0];
        end
        default: ;
      endcase
    end
    pend_d = pend_d | sw_change;
  end

  assign tick = (pre_cnt_q == presc_q);

  always_comb begin
    if ((apb_wr && sel == REG_PRESC) || tick) pre_cnt_d = '0;
    else                                      pre_cnt_d = pre_cnt_q + 16'd1;
    pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    led_d = '0;
    for (int n = 0; n < NUM_LED; n++)
      led_d[n] = led_en_q[n] & ((duty_q[n] == '1) | (pwm_cnt_q < duty_q[n]));
    irq_d = |(pend_q & irq_en_q);
  end

  always_ff @(posedge io_systemClk or posedge io_systemReset) begin
    if (io_systemReset) begin
      led_en_q  <= '0;
      presc_q   <= '0;
      irq_en_q  <= '0;
      pend_q    <= '0;
      db_th_q   <= '1;
      for (int n = 0; n < NUM_LED; n++) duty_q[n] <= '1;
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      led_en_q  <= led_en_d;
      presc_q   <= presc_d;
      irq_en_q  <= irq_en_d;
      pend_q    <= pend_d;
      db_th_q   <= db_th_d;
      duty_q    <= duty_d;
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      irq_q     <= irq_d;
    end
  end

  assign o_led = led_q;
  assign o_irq = irq_q;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    sw_debounce #(.DB_BITS(DB_BITS)) u_db (
      .clk_i    (io_systemClk),
      .rst_i    (io_systemReset),
      .sw_i     (i_sw[g]),
      .db_th_i  (db_th_q),
      .stable_o (sw_stable[g]),
      .change_o (sw_change[g])
    );
  end

endmodule

// File: tb/tb_apb_led_sw_ctrl.sv
// Self-checking bench for apb_led_sw_ctrl: register-map vector table, PWM
// duty measurement against an arithmetic model, debounce/IRQ and reset sequences.
module tb_apb_led_sw_ctrl;

  localparam int NUM_LED  = 8;
  localparam int NUM_SW   = 4;
  localparam int PWM_BITS = 8;
  localparam int DB_BITS  = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        paddr;
  logic               psel, penable, pwrite;
  logic [31:0]        pwdata, prdata;
  logic               pready, pslverr;
  logic [NUM_LED-1:0] o_led;
  logic [NUM_SW-1:0]  i_sw;
  logic               o_irq;

  always #5 clk = ~clk;

  apb_led_sw_ctrl #(
    .NUM_LED(NUM_LED), .NUM_SW(NUM_SW), .PWM_BITS(PWM_BITS), .DB_BITS(DB_BITS)
  ) dut (
    .io_systemClk          (clk),
    .io_systemReset        (rst),
    .io_apbSlave_PADDR     (paddr),
    .io_apbSlave_PSEL      (psel),
    .io_apbSlave_PENABLE   (penable),
    .io_apbSlave_PWRITE    (pwrite),
    .io_apbSlave_PWDATA    (pwdata),
    .io_apbSlave_PRDATA    (prdata),
    .io_apbSlave_PREADY    (pready),
    .io_apbSlave_PSLVERROR (pslverr),
    .o_led                 (o_led),
    .i_sw                  (i_sw),
    .o_irq                 (o_irq)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int hi [NUM_LED];

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vecs [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    d = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, e);
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_read(a, d, e);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; i_sw = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic measure(input int cycles);
    for (int n = 0; n < NUM_LED; n++) hi[n] = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int n = 0; n < NUM_LED; n++) hi[n] += int'(o_led[n]);
    end
  endtask

  // Expected high cycles over one full PWM period of 2^PWM_BITS*(presc+1) cycles.
  function automatic int exp_high(input logic en, input int duty, input int presc);
    if (!en) return 0;
    if (duty == (1 << PWM_BITS) - 1) return (1 << PWM_BITS) * (presc + 1);
    return duty * (presc + 1);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          others, early, bit13;
    int          p, en, dv [NUM_LED];

    vecs[0]  = '{1'b0, 16'h0000, 32'h0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 16'h0008, 32'h0, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 16'h0010, 32'h0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 16'h0018, 32'h0, 32'h01040808, 1'b0};
    vecs[4]  = '{1'b0, 16'h001C, 32'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 16'h0060, 32'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 16'h0004, 32'h0, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 16'h0014, 32'h0, 32'h0000FFFF, 1'b0};
    vecs[8]  = '{1'b0, 16'h0040, 32'h0, 32'h000000FF, 1'b0};
    vecs[9]  = '{1'b0, 16'h005C, 32'h0, 32'h000000FF, 1'b0};
    vecs[10] = '{1'b0, 16'h0042, 32'h0, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 16'h001C, 32'hFFFFFFFF, 32'h0, 1'b1};
    vecs[12] = '{1'b1, 16'h0000, 32'hFFFFFFA5, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 32'h0, 32'h000000A5, 1'b0};
    vecs[14] = '{1'b1, 16'h0004, 32'h00012345, 32'h0, 1'b0};
    vecs[15] = '{1'b0, 16'h0004, 32'h0, 32'h00002345, 1'b0};
    vecs[16] = '{1'b1, 16'h000C, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[17] = '{1'b0, 16'h000C, 32'h0, 32'h0000000F, 1'b0};
    vecs[18] = '{1'b1, 16'h0048, 32'h00001234, 32'h0, 1'b0};
    vecs[19] = '{1'b0, 16'h0048, 32'h0, 32'h00000034, 1'b0};
    vecs[20] = '{1'b1, 16'h0008, 32'h0000000F, 32'h0, 1'b0};
    vecs[21] = '{1'b0, 16'h0008, 32'h0, 32'h0,        1'b0};
    vecs[22] = '{1'b1, 16'h0018, 32'h0, 32'h0,        1'b0};
    vecs[23] = '{1'b0, 16'h0018, 32'h0, 32'h01040808, 1'b0};
    vecs[24] = '{1'b0, 16'h0044, 32'h0, 32'h000000FF, 1'b0};
    vecs[25] = '{1'b1, 16'h0060, 32'h0, 32'h0,        1'b1};
    vecs[26] = '{1'b0, 16'h0014, 32'h0, 32'h0000FFFF, 1'b0};

    rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; i_sw = '0;
    do_reset();

    @(negedge clk);
    check("reset_o_led", 32'(o_led), 32'h0);
    check("reset_o_irq", 32'(o_irq), 32'h0);
    check("reset_pready", 32'(pready), 32'h1);
    paddr = 16'h0018;
    #1 check("prdata_idle_zero", prdata, 32'h0);

    for (int i = 0; i < 27; i++) begin
      if (vecs[i].wr) begin
        apb_write(vecs[i].addr, vecs[i].wdata, e);
        check($sformatf("vec%0d_wr_err", i), 32'(e), 32'(vecs[i].exp_err));
      end else begin
        apb_read(vecs[i].addr, d, e);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
        check($sformatf("vec%0d_rd_err", i), 32'(e), 32'(vecs[i].exp_err));
      end
    end

    // PWM hand sequences
    do_reset();
    wr(16'h0000, 32'h01);
    wr(16'h0040, 32'h40);
    wr(16'h0004, 32'h0);
    repeat (4) @(posedge clk);
    measure(256);
    check("pwm_duty40_high", 32'(hi[0]), 32'd64);
    others = 0;
    for (int n = 1; n < NUM_LED; n++) others += hi[n];
    check("pwm_disabled_off", 32'(others), 32'd0);
    wr(16'h0040, 32'hFF);
    repeat (3) @(posedge clk);
    measure(256);
    check("pwm_dutyFF_on", 32'(hi[0]), 32'd256);
    wr(16'h0040, 32'h00);
    repeat (3) @(posedge clk);
    measure(256);
    check("pwm_duty00_off", 32'(hi[0]), 32'd0);
    wr(16'h0040, 32'h80);
    wr(16'h0004, 32'h3);
    repeat (4) @(posedge clk);
    measure(1024);
    check("pwm_presc3_high", 32'(hi[0]), 32'd512);

    // Randomised PWM against the period-count model
    for (int it = 0; it < 6; it++) begin
      p  = int'($urandom_range(0, 2));
      en = int'($urandom_range(0, 255));
      for (int n = 0; n < NUM_LED; n++) begin
        case ($urandom_range(0, 9))
          0:       dv[n] = 0;
          1:       dv[n] = 255;
          default: dv[n] = int'($urandom_range(1, 254));
        endcase
        wr(16'(16'h0040 + 4 * n), 32'(dv[n]));
      end
      wr(16'h0000, 32'(en));
      wr(16'h0004, 32'(p));
      repeat (4) @(posedge clk);
      measure(256 * (p + 1));
      for (int n = 0; n < NUM_LED; n++)
        check($sformatf("rnd%0d_led%0d", it, n), 32'(hi[n]),
              32'(exp_high(en[n], dv[n], p)));
    end

    // Debounce with bounces shorter than the threshold, then a clean rise
    do_reset();
    wr(16'h0014, 32'd10);
    wr(16'h000C, 32'h2);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0008;
    early = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1 i_sw[1] = ((c / 5) % 2 == 0);
      @(negedge clk);
      if (prdata[1]) early++;
    end
    @(posedge clk); #1 i_sw[1] = 1'b1;
    bit13 = 0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #2;
      if (k < 13 && prdata[1]) early++;
      if (k == 13) begin
        bit13 = int'(prdata[1]);
        check("irq_not_before_pend", 32'(o_irq), 32'h0);
      end
    end
    check("db_no_early_change", 32'(early), 32'd0);
    check("db_rise_after_13", 32'(bit13), 32'd1);
    @(posedge clk); #2;
    check("irq_one_cycle_after", 32'(o_irq), 32'h1);
    #1 psel = 1'b0;
    rd_check("pend_after_rise", 16'h0010, 32'h2);
    rd_check("sw_state_after_rise", 16'h0008, 32'h2);
    wr(16'h0010, 32'h2);
    @(posedge clk); #1;
    check("irq_cleared_w1c", 32'(o_irq), 32'h0);
    rd_check("pend_cleared_w1c", 16'h0010, 32'h0);

    // W1C colliding with a new change: set wins
    wr(16'h0014, 32'd0);
    @(posedge clk); #1 i_sw[1] = 1'b0;
    apb_write(16'h0010, 32'h2, e);
    rd_check("pend_set_wins", 16'h0010, 32'h2);
    check("irq_set_wins", 32'(o_irq), 32'h1);
    rd_check("sw_state_fall_th0", 16'h0008, 32'h0);

    // Reset asserted mid-operation
    wr(16'h0000, 32'hFF);
    wr(16'h0004, 32'h5);
    wr(16'h000C, 32'hF);
    @(posedge clk); #1 i_sw[2] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_reset_leds_on", 32'(o_led), 32'hFF);
    check("pre_reset_irq_on", 32'(o_irq), 32'h1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async_reset_o_led", 32'(o_led), 32'h0);
    check("async_reset_o_irq", 32'(o_irq), 32'h0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = 16'h0000; #1 check("rst_led_en", prdata, 32'h0);
    paddr = 16'h0004; #1 check("rst_presc", prdata, 32'h0);
    paddr = 16'h000C; #1 check("rst_irq_en", prdata, 32'h0);
    paddr = 16'h0010; #1 check("rst_pend", prdata, 32'h0);
    paddr = 16'h0008; #1 check("rst_sw_state", prdata, 32'h0);
    paddr = 16'h0014; #1 check("rst_db_th", prdata, 32'h0000FFFF);
    paddr = 16'h0040; #1 check("rst_duty0", prdata, 32'h000000FF);
    psel = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
